uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage. It sits directly downstream of the transmitter and consumes its serial line. Each frame is 1 start bit, 8 data bits LSB-first, 1 even-parity bit and 1 stop bit. Start detection, data sampling and the stop check run on a 16x-oversampled baud tick, and each received byte is presented with a one-cycle valid strobe plus parity and framing error flags.

## Interface
Reset is synchronous and active-high. The block uses one clock, `Clock_In`. `Reset` is sampled on the rising edge of `Clock_In`.

Parameters:
- `CLK_FREQ`, default 50_000_000: `Clock_In` frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `OVERSAMPLE`, fixed at 16: ticks per bit.
- `DIV`, derived as `CLK_FREQ/(BAUD*16)` with truncating integer division (325 at the defaults): clocks per tick. `DIV` must be at least 2.

Ports:
- `Clock_In`, input, 1 bit: system clock.
- `Reset`, input, 1 bit: synchronous, active-high.
- `Rx_dataIn`, input, 1 bit: asynchronous serial line; idle level is 1.
- `Rx_data`, output, 8 bits: last received byte.
- `Rx_valid`, output, 1 bit: single-cycle strobe; `Rx_data` and the error flags are valid in that cycle.
- `Parity_Err`, output, 1 bit: received parity bit does not match the even parity of `Rx_data`.
- `Frame_Err`, output, 1 bit: stop bit sampled as 0.
- `Rx_busy`, output, 1 bit: high whenever the FSM is not IDLE.
- `Baud_Tick`, output, 1 bit: 16x tick, exported for debug.

## Operation
- **Input synchroniser:** `Rx_dataIn` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised signal `rx_s`.
- **Tick generator:** counts 0 to DIV-1 and pulses `Baud_Tick` when the count equals DIV-1. It is cleared to 0 in the cycle a start edge is accepted, so bit sampling is aligned to that edge.
- **Sample counter:** 4-bit counter `scnt`, advanced on each tick.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** wait for a falling edge on `rx_s` (previous value 1, current value 0). On the edge: clear the tick and `scnt` counters, then go to START. A line held low never triggers a new frame; it must return to 1 and then fall again.
  - **START:** on the tick where `scnt`=7 (mid-bit), sample `rx_s`.
    - `rx_s`=1: false start; go to IDLE with no output.
    - `rx_s`=0: clear `scnt`, then go to DATA.
  - **DATA:** on each tick where `scnt`=15, sample the bit into the shift register, LSB first. Count bits 0 to 7. After bit 7, go to PARITY.
  - **PARITY:** on the tick where `scnt`=15, capture the parity bit, then go to STOP.
  - **STOP:** on the tick where `scnt`=15, sample the stop bit, then in the same cycle:
    - load `Rx_data` from the shift register;
    - set `Parity_Err` = (XOR of the 8 data bits) XOR (parity bit);
    - set `Frame_Err` = NOT (stop bit);
    - pulse `Rx_valid`;
    - go to IDLE.
- **Error reporting:** the byte is delivered even when an error flag is set.
- **Flag and data persistence:** `Rx_data`, `Parity_Err` and `Frame_Err` hold their values until the next `Rx_valid`.
- **Reset mid-frame:** `Reset` aborts any frame in progress. The FSM goes to IDLE and no `Rx_valid` is generated for the aborted frame.

## Timing
- **Reset values:**
  - `Rx_data`=0x00, `Rx_valid`=0, `Parity_Err`=0, `Frame_Err`=0, `Rx_busy`=0, `Baud_Tick`=0.
  - FSM in IDLE; all counters 0; synchroniser flops 1.
- **Start-edge latency:** a falling edge on `Rx_dataIn` is seen 2 clocks later on `rx_s`. `Rx_busy` rises on the next clock.
- **Sample point:** each bit is sampled 8 ticks after its nominal start, i.e. at mid-bit.
- **Output latency:** `Rx_valid` fires (10×16 + 8) ticks = 168×DIV clocks, ±1 clock, after the start edge is accepted. At the defaults this is 54600 clocks.
- **Back-to-back frames:** because the stop bit is sampled at mid-bit, the FSM is back in IDLE before the next start edge. This holds with zero idle time between frames.
- **Reset vs. sample:** if `Reset` and a sample tick occur in the same cycle, `Reset` wins.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `DATA_BITS`=8;
  - `OVERSAMPLE`=16;
  - `MID_SAMPLE`=7;
  - even-parity convention.
  
  The transmitter shares this package.
- **Sub-module `uart_baud_tick`:** contains the DIV counter, the synchronous clear input and the tick output. It is instantiated once.
- **Remaining logic** (FSM, shift register and output registers) lives in `uart_receiver`.

## Test plan
Benches use BAUD and CLK_FREQ chosen so that DIV=4, giving 64 clocks per bit.

1. **Clean frame:** drive 0xC4 with parity bit 1 and stop bit 1. Expect `Rx_data`=0xC4, one-cycle `Rx_valid`, `Parity_Err`=0, `Frame_Err`=0, with `Rx_valid` 672±1 clocks after the start edge is accepted.
2. **Parity error:** drive 0xC4 with parity bit 0. Expect `Rx_data`=0xC4, `Rx_valid`=1, `Parity_Err`=1, `Frame_Err`=0.
3. **Framing error, then line held low:** drive 0x5A with stop bit 0, then hold the line low for 5 bit times. Expect `Frame_Err`=1 on the single `Rx_valid`, and no further `Rx_valid` until the line returns high and a new valid frame is sent.
4. **Glitch rejection:** pulse the line low for 20 clocks, which is shorter than half a bit. Expect no `Rx_valid`, and `Rx_busy` to return to 0 within one bit time.
5. **Back-to-back frames:** send 0xC4 then 0xC5 (parity 0) with no idle gap. Expect two `Rx_valid` pulses 704 clocks apart, carrying 0xC4 and 0xC5, with no error flags.
6. **Reset mid-frame:** assert `Reset` for 1 clock during data bit 3. Expect all outputs to return to their reset values and no `Rx_valid` for the aborted frame. A following full frame of 0x5A (parity 0) must be received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive and transmit stages.
//   rx_state_t  - receiver FSM state encoding
//   DATA_BITS   - payload bits per frame (LSB first on the line)
//   OVERSAMPLE  - baud ticks per bit period
//   MID_SAMPLE  - tick index inside the start bit used as its mid-bit sample
//   even_parity - parity bit value that makes the total count of ones even
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_BITS   = 8;
  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = OVERSAMPLE - 1;

  // Even parity: the parity bit equals the XOR of the data bits, so the
  // frame carries an even number of ones across data + parity.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk down to the oversampling tick.
//   clk   - system clock
//   srst  - synchronous active-high reset (counter to 0)
//   clear - synchronous restart of the divider, used to phase-align the
//           tick to an accepted start edge
//   tick  - high for one clk when the divider count reaches DIV-1
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Decoded straight from the count register so the tick is a clean
  // one-cycle pulse; it is 0 out of reset because DIV is at least 2.
  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART receive stage, 16x oversampled.
//   Clock_In   - system clock
//   Reset      - synchronous active-high reset, aborts any frame in flight
//   Rx_dataIn  - asynchronous serial line, idle high
//   Rx_data    - last received byte, held until the next Rx_valid
//   Rx_valid   - one-cycle strobe qualifying Rx_data and the error flags
//   Parity_Err - received parity bit disagrees with even parity of Rx_data
//   Frame_Err  - stop bit was sampled low
//   Rx_busy    - FSM is not idle
//   Baud_Tick  - 16x oversampling tick, for debug
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       Clock_In,
  input  logic       Reset,
  input  logic       Rx_dataIn,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  output logic       Parity_Err,
  output logic       Frame_Err,
  output logic       Rx_busy,
  output logic       Baud_Tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [3:0] SCNT_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SCNT_LAST = 4'(LAST_SAMPLE);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  // Two-flop synchroniser plus one more flop holding the previous
  // synchronised value for edge detection. All reset to the idle level so
  // that reset never manufactures a falling edge on an idle line.
  logic sync1_reg;
  logic rx_s_reg;
  logic rx_prev_reg;

  always_ff @(posedge Clock_In) begin
    if (Reset) begin
      sync1_reg   <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= Rx_dataIn;
      rx_s_reg    <= sync1_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  logic baud_tick;
  logic tick_clear;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk  (Clock_In),
    .srst (Reset),
    .clear(tick_clear),
    .tick (baud_tick)
  );

  rx_state_t            state_reg,  state_next;
  logic [3:0]           scnt_reg,   scnt_next;
  logic [2:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,  shift_next;
  logic                 parity_reg, parity_next;
  logic [DATA_BITS-1:0] data_reg,   data_next;
  logic                 perr_reg,   perr_next;
  logic                 ferr_reg,   ferr_next;
  logic                 valid_reg,  valid_next;

  always_ff @(posedge Clock_In) begin
    if (Reset) begin
      state_reg   <= IDLE;
      scnt_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      data_reg    <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      scnt_reg    <= scnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      data_reg    <= data_next;
      perr_reg    <= perr_next;
      ferr_reg    <= ferr_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    scnt_next    = scnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    data_next    = data_reg;
    perr_next    = perr_reg;
    ferr_next    = ferr_reg;
    valid_next   = 1'b0;
    tick_clear   = 1'b0;

    // scnt free-runs modulo 16 on ticks; the 15 -> 0 wrap is what spaces
    // successive samples exactly one bit period apart.
    if (baud_tick) begin
      scnt_next = scnt_reg + 4'd1;
    end

    case (state_reg)
      IDLE: begin
        // Only a 1 -> 0 transition starts a frame, so a line stuck low
        // (break or framing fault) cannot retrigger reception.
        if (rx_prev_reg && !rx_s_reg) begin
          tick_clear = 1'b1;
          scnt_next  = '0;
          state_next = START;
        end
      end

      START: begin
        if (baud_tick && scnt_reg == SCNT_MID) begin
          if (rx_s_reg) begin
            state_next = IDLE;          // glitch: line already high again
          end else begin
            scnt_next    = '0;          // rebase so scnt=15 lands mid-bit
            bit_cnt_next = '0;
            state_next   = DATA;
          end
        end
      end

      DATA: begin
        if (baud_tick && scnt_reg == SCNT_LAST) begin
          shift_next   = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = PARITY;
          end
        end
      end

      PARITY: begin
        if (baud_tick && scnt_reg == SCNT_LAST) begin
          parity_next = rx_s_reg;
          state_next  = STOP;
        end
      end

      STOP: begin
        // Leaving at mid stop bit gives half a bit of margin to be back in
        // IDLE before a back-to-back start edge.
        if (baud_tick && scnt_reg == SCNT_LAST) begin
          data_next  = shift_reg;
          perr_next  = even_parity(shift_reg) ^ parity_reg;
          ferr_next  = ~rx_s_reg;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Rx_data    = data_reg;
  assign Rx_valid   = valid_reg;
  assign Parity_Err = perr_reg;
  assign Frame_Err  = ferr_reg;
  assign Rx_busy    = (state_reg != IDLE);
  assign Baud_Tick  = baud_tick;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at DIV=4 (64 clocks per bit). Frames are driven
// bit by bit; every received byte is logged with its cycle number and then
// checked against a queue of expected results filled by each scenario.
module tb_uart_receiver;

  localparam int BAUD     = 9600;
  localparam int CLK_FREQ = 614_400;    // 614400 / (9600*16) = 4
  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       perr;
  logic       ferr;
  logic       busy;
  logic       btick;

  uart_receiver #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .Clock_In  (clk),
    .Reset     (rst),
    .Rx_dataIn (line),
    .Rx_data   (rx_data),
    .Rx_valid  (rx_valid),
    .Parity_Err(perr),
    .Frame_Err (ferr),
    .Rx_busy   (busy),
    .Baud_Tick (btick)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        pe;
    logic        fe;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: count the edge, then sample on the falling edge and log any
  // Rx_valid cycle. Stimulus changes right after this returns.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rx_valid === 1'b1) obs_q.push_back('{cyc, rx_data, perr, ferr});
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (BIT_CLKS) step();
  endtask

  task automatic send_tail(input logic [7:0] d, input logic p, input logic s);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    send_tail(d, p, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line = 1'b1;
    repeat (3) step();
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (btick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", btick); end
    rst = 1'b0;
    drive_bit(1'b1);
    $display("reset: outputs checked, errors so far %0d", errors);
  endtask

  task automatic test_clean();
    int unsigned start;
    int unsigned lat;
    obs_t o;
    exp_t e;
    exp_q.push_back('{8'hC4, 1'b0, 1'b0});
    start = cyc;
    line = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_early: got %b want 0", busy); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_rise: got %b want 1", busy); end
    repeat (BIT_CLKS - 3) step();
    send_tail(8'hC4, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL clean_count: got %0d valid cycles want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        errors++; $display("FAIL clean_byte: got %h pe=%b fe=%b want %h pe=%b fe=%b", o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
      lat = o.cyc - start - 3;   // 2 synchroniser clocks + 1 to accept
      checks++;
      if (lat < 671 || lat > 673) begin
        errors++; $display("FAIL clean_latency: got %0d clocks want 672+-1", lat);
      end
      $display("clean: byte %h pe=%b fe=%b latency %0d", o.data, o.pe, o.fe, lat);
    end
    exp_q.delete();
  endtask

  task automatic test_parity();
    obs_t o;
    exp_t e;
    exp_q.push_back('{8'hC4, 1'b1, 1'b0});
    send_frame(8'hC4, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL parity_count: got %0d valid cycles want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        errors++; $display("FAIL parity_byte: got %h pe=%b fe=%b want %h pe=%b fe=%b", o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
      $display("parity: byte %h pe=%b fe=%b", o.data, o.pe, o.fe);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_framing();
    obs_t o;
    exp_t e;
    exp_q.push_back('{8'h5A, 1'b0, 1'b1});
    send_frame(8'h5A, 1'b0, 1'b0);
    repeat (5) drive_bit(1'b0);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL framing_count: got %0d valid cycles want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        errors++; $display("FAIL framing_byte: got %h pe=%b fe=%b want %h pe=%b fe=%b", o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
      $display("framing: byte %h pe=%b fe=%b", o.data, o.pe, o.fe);
    end
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL framing_hold: got %b want 1", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_low_busy: got %b want 0", busy); end
    exp_q.delete();
    obs_q.delete();
    drive_bit(1'b1);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL framing_recover_count: got %0d valid cycles want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        errors++; $display("FAIL framing_recover_byte: got %h pe=%b fe=%b want %h pe=%b fe=%b", o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
      $display("framing recover: byte %h pe=%b fe=%b", o.data, o.pe, o.fe);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_glitch();
    logic seen_busy;
    seen_busy = 1'b0;
    line = 1'b0;
    repeat (20) begin step(); if (busy === 1'b1) seen_busy = 1'b1; end
    line = 1'b1;
    repeat (BIT_CLKS - 20) begin step(); if (busy === 1'b1) seen_busy = 1'b1; end
    checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_seen: busy never rose, got %b want 1", seen_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0 after one bit", busy); end
    repeat (11) drive_bit(1'b1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles want 0", obs_q.size()); end
    $display("glitch: busy_seen=%b busy_now=%b valids=%0d", seen_busy, busy, obs_q.size());
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    exp_t e;
    exp_q.push_back('{8'hC4, 1'b0, 1'b0});
    exp_q.push_back('{8'hC5, 1'b0, 1'b0});
    send_frame(8'hC4, 1'b1, 1'b1);
    send_frame(8'hC5, 1'b0, 1'b1);
    drive_bit(1'b1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d valid cycles want 2", obs_q.size());
    end else begin
      o1 = obs_q.pop_front();
      o2 = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o1.data !== e.data || o1.pe !== e.pe || o1.fe !== e.fe) begin
        errors++; $display("FAIL b2b_first: got %h pe=%b fe=%b want %h pe=%b fe=%b", o1.data, o1.pe, o1.fe, e.data, e.pe, e.fe);
      end
      e = exp_q.pop_front();
      checks++;
      if (o2.data !== e.data || o2.pe !== e.pe || o2.fe !== e.fe) begin
        errors++; $display("FAIL b2b_second: got %h pe=%b fe=%b want %h pe=%b fe=%b", o2.data, o2.pe, o2.fe, e.data, e.pe, e.fe);
      end
      checks++;
      if (o2.cyc - o1.cyc != 704) begin
        errors++; $display("FAIL b2b_spacing: got %0d clocks want 704", o2.cyc - o1.cyc);
      end
      $display("b2b: %h then %h, spacing %0d", o1.data, o2.data, o2.cyc - o1.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    // 0xF8 with parity 1: line stays high from data bit 3 to the stop bit,
    // so no falling edge follows the reset.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    line = 1'b1;
    repeat (30) step();
    rst = 1'b1;
    step();
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b want 0", perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (BIT_CLKS - 31) step();
    repeat (6) drive_bit(1'b1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_aborted: got %0d valid cycles want 0", obs_q.size()); end
    obs_q.delete();
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL midrst_next_count: got %0d valid cycles want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        errors++; $display("FAIL midrst_next_byte: got %h pe=%b fe=%b want %h pe=%b fe=%b", o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
      $display("reset mid-frame: next byte %h pe=%b fe=%b", o.data, o.pe, o.fe);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst  = 1'b1;
    line = 1'b1;
    test_reset();
    test_clean();
    drive_bit(1'b1);
    test_parity();
    drive_bit(1'b1);
    test_framing();
    drive_bit(1'b1);
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
